itr_ctrl: RTL and testbench



---
 rtl/itr_ctrl_pkg.sv | 15 +
 rtl/itr_ctrl_if.sv | 30 +++
 rtl/itr_ctrl_arb.sv | 28 ++
 rtl/itr_ctrl.sv | 100 ++++++++++
 tb/tb_itr_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/itr_ctrl_pkg.sv
// Shared types and command codes for the itr_ctrl interrupt controller.
// Build option: define ITR_CTRL_RR_EN for round-robin arbitration (default fixed priority).
package itr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC
    } state_t;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_CLR  = 2'd1;
    localparam logic [1:0] CFG_EOI  = 2'd2;

endpackage

// File: rtl/itr_ctrl_if.sv
// Bus bundle between the core-side I/O decode (master) and itr_ctrl (slave).
// Build option ITR_CTRL_RR_EN does not affect this interface.
interface itr_ctrl_if #(
    parameter int NSRC   = 4,
    parameter int MINSTW = 9
);
    localparam int IDW = $clog2(NSRC);

    logic [NSRC-1:0]   irq_in;
    logic [MINSTW-1:0] instr_addr;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [NSRC-1:0]   cfg_data;
    logic              itr;
    logic [IDW-1:0]    src_id;
    logic              in_service;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   mask;

    modport master (
        output irq_in, instr_addr, cfg_we, cfg_sel, cfg_data,
        input  itr, src_id, in_service, pending, mask
    );

    modport slave (
        input  irq_in, instr_addr, cfg_we, cfg_sel, cfg_data,
        output itr, src_id, in_service, pending, mask
    );

endinterface

// File: rtl/itr_ctrl_arb.sv
// Combinational winner select: first set request searching upward from ptr+1, wrapping.
// Under the default build (ITR_CTRL_RR_EN undefined) ptr is tied to NSRC-1, giving lowest-index priority.
module itr_arb #(
    parameter int NSRC = 4,
    parameter int IDW  = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    int unsigned idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = (32'(ptr) + 1 + k) % NSRC;
            if (!valid && req[IDW'(idx)]) begin
                valid  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: edge-latched pending, mask, arbitration and IDLE/REQ/SVC handshake with the core.
// Build option: define ITR_CTRL_RR_EN for round-robin arbitration (default fixed priority, lowest index).
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int MINSTW = 9,
    parameter int ITRADD = 1
) (
    input logic       clk,
    input logic       rst,
    itr_ctrl_if.slave bus
);

    localparam int IDW = $clog2(NSRC);

    state_t          state, next_state;
    logic [NSRC-1:0] irq_d, pending_q, mask_q;
    logic [NSRC-1:0] rises, clr_vec, gnt_vec;
    logic [IDW-1:0]  src_q, winner, ptr;
    logic            itr_q, in_service_q, itr_nx, svc_nx;
    logic            arb_valid, grant, eoi, ack;

    assign rises   = bus.irq_in & ~irq_d;
    assign eoi     = bus.cfg_we && (bus.cfg_sel == CFG_EOI);
    assign clr_vec = (bus.cfg_we && (bus.cfg_sel == CFG_CLR)) ? bus.cfg_data : '0;
    assign ack     = (bus.instr_addr == MINSTW'(ITRADD));
    assign grant   = (state == IDLE) && arb_valid;
    assign gnt_vec = grant ? (NSRC'(1) << winner) : '0;

`ifdef ITR_CTRL_RR_EN
    logic [IDW-1:0] last_q;

    always_ff @(posedge clk) begin
        if (rst)        last_q <= '0;
        else if (grant) last_q <= winner;
    end

    assign ptr = last_q;
`else
    assign ptr = IDW'(NSRC - 1);
`endif

    itr_arb #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_arb (
        .req    (pending_q & mask_q),
        .ptr    (ptr),
        .valid  (arb_valid),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (arb_valid) next_state = REQ;
            REQ:     if (ack)       next_state = SVC;
            SVC:     if (eoi)       next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered copies line up with the state register.
    always_comb begin
        itr_nx = (next_state == REQ);
        svc_nx = (next_state == SVC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d        <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            src_q        <= '0;
            itr_q        <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            irq_d        <= bus.irq_in;
            // Edges are OR-ed last so a new event survives both a clear and its own grant.
            pending_q    <= (pending_q & ~clr_vec & ~gnt_vec) | rises;
            itr_q        <= itr_nx;
            in_service_q <= svc_nx;
            if (bus.cfg_we && (bus.cfg_sel == CFG_MASK)) mask_q <= bus.cfg_data;
            if (grant) src_q <= winner;
        end
    end

    assign bus.itr        = itr_q;
    assign bus.src_id     = src_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Self-checking bench for itr_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Honours ITR_CTRL_RR_EN the same way as the design.
module tb_itr_ctrl;

    localparam int NSRC   = 4;
    localparam int MINSTW = 9;
    localparam int ITRADD = 1;
    localparam int IDW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    itr_ctrl_if #(.NSRC(NSRC), .MINSTW(MINSTW)) bus ();

    itr_ctrl #(.NSRC(NSRC), .MINSTW(MINSTW), .ITRADD(ITRADD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = handler running.
    bit [NSRC-1:0] m_prev, m_pend, m_mask;
    int            m_phase, m_src, m_last;

    function automatic void model_update();
        bit [NSRC-1:0] rises, nxt;
        int win, c;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_mask = '0;
            m_phase = 0; m_src = 0; m_last = 0;
            return;
        end
        rises = bus.irq_in & ~m_prev;
        win = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < NSRC; k++) begin
`ifdef ITR_CTRL_RR_EN
                c = (m_last + 1 + k) % NSRC;
`else
                c = k;
`endif
                if (win < 0 && m_pend[c] && m_mask[c]) win = c;
            end
        end
        nxt = m_pend;
        if (bus.cfg_we && bus.cfg_sel == 2'd1) nxt &= ~bus.cfg_data;
        if (win >= 0) begin
            nxt[win] = 1'b0;
            m_src = win;
            m_last = win;
        end
        nxt |= rises;
        case (m_phase)
            0: if (win >= 0) m_phase = 1;
            1: if (bus.instr_addr == ITRADD) m_phase = 2;
            2: if (bus.cfg_we && bus.cfg_sel == 2'd2) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (bus.cfg_we && bus.cfg_sel == 2'd0) m_mask = bus.cfg_data;
        m_prev = bus.irq_in;
        m_pend = nxt;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cmd(input logic [1:0] sel, input logic [NSRC-1:0] data);
        bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0; bus.cfg_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.irq_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic ack_and_eoi();
        bus.instr_addr = MINSTW'(ITRADD);
        tick();
        bus.instr_addr = '0;
        cmd(2'd2, '0);
    endtask

    task automatic test_reset();
        tick();
        do_reset();
        checks++; if (bus.itr !== 1'b0) begin failures++; $display("FAIL reset_itr: got %0b want 0", bus.itr); end
        checks++; if (bus.src_id !== '0) begin failures++; $display("FAIL reset_src: got %0d want 0", bus.src_id); end
        checks++; if (bus.in_service !== 1'b0) begin failures++; $display("FAIL reset_svc: got %0b want 0", bus.in_service); end
        checks++; if (bus.pending !== '0 || bus.mask !== '0) begin failures++; $display("FAIL reset_regs: pending %b mask %b want 0", bus.pending, bus.mask); end
    endtask

    task automatic test_basic();
        cmd(2'd0, 4'b1111);
        bus.irq_in = 4'b0100; tick();
        checks++; if (bus.pending !== 4'b0100 || bus.itr !== 1'b0) begin failures++; $display("FAIL basic_pend: pending %b itr %0b want 0100/0", bus.pending, bus.itr); end
        bus.irq_in = '0; tick();
        checks++; if (bus.itr !== 1'b1 || bus.src_id !== 2'd2) begin failures++; $display("FAIL basic_grant: itr %0b src %0d want 1/2", bus.itr, bus.src_id); end
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL basic_pclr: got %b want 0000", bus.pending); end
        bus.instr_addr = MINSTW'(ITRADD); tick();
        bus.instr_addr = '0;
        checks++; if (bus.itr !== 1'b0 || bus.in_service !== 1'b1) begin failures++; $display("FAIL basic_ack: itr %0b svc %0b want 0/1", bus.itr, bus.in_service); end
        cmd(2'd2, '0);
        checks++; if (bus.in_service !== 1'b0) begin failures++; $display("FAIL basic_eoi: svc %0b want 0", bus.in_service); end
    endtask

    task automatic test_masked();
        cmd(2'd0, 4'b0001);
        bus.irq_in = 4'b1000; tick();
        bus.irq_in = '0; tick();
        checks++; if (bus.itr !== 1'b0 || bus.pending !== 4'b1000) begin failures++; $display("FAIL masked_hold: itr %0b pending %b want 0/1000", bus.itr, bus.pending); end
        cmd(2'd0, 4'b1000);
        tick();
        checks++; if (bus.itr !== 1'b1 || bus.src_id !== 2'd3) begin failures++; $display("FAIL masked_grant: itr %0b src %0d want 1/3", bus.itr, bus.src_id); end
        ack_and_eoi();
    endtask

    task automatic test_priority();
        cmd(2'd0, 4'b1111);
        bus.irq_in = 4'b1010; tick();
        bus.irq_in = '0; tick();
        checks++; if (bus.itr !== 1'b1 || bus.src_id !== 2'd1) begin failures++; $display("FAIL prio_first: itr %0b src %0d want 1/1", bus.itr, bus.src_id); end
        bus.instr_addr = MINSTW'(ITRADD); tick();
        bus.instr_addr = '0;
        cmd(2'd2, '0);
        checks++; if (bus.itr !== 1'b0 || bus.in_service !== 1'b0) begin failures++; $display("FAIL prio_idle: itr %0b svc %0b want 0/0", bus.itr, bus.in_service); end
        tick();
        checks++; if (bus.itr !== 1'b1 || bus.src_id !== 2'd3) begin failures++; $display("FAIL prio_second: itr %0b src %0d want 1/3", bus.itr, bus.src_id); end
        ack_and_eoi();
    endtask

`ifdef ITR_CTRL_RR_EN
    task automatic test_round_robin();
        logic [IDW-1:0] want;
        do_reset();
        cmd(2'd0, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'd1 : 2'd0;
            bus.irq_in = 4'b0011; tick();
            bus.irq_in = '0; tick();
            checks++; if (bus.itr !== 1'b1 || bus.src_id !== want) begin failures++; $display("FAIL rr_grant%0d: itr %0b src %0d want 1/%0d", i, bus.itr, bus.src_id, want); end
            ack_and_eoi();
        end
    endtask
`endif

    task automatic test_set_beats_clear();
        do_reset();
        cmd(2'd0, 4'b0100);
        bus.irq_in = 4'b0100; tick();
        bus.irq_in = '0; tick();
        bus.instr_addr = MINSTW'(ITRADD); tick();
        bus.instr_addr = '0;
        bus.irq_in = 4'b0001;
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 4'b0001;
        tick();
        bus.irq_in = '0; bus.cfg_we = 1'b0; bus.cfg_data = '0;
        checks++; if (bus.pending !== 4'b0001 || bus.in_service !== 1'b1) begin failures++; $display("FAIL setclr: pending %b svc %0b want 0001/1", bus.pending, bus.in_service); end
        cmd(2'd2, '0);
        cmd(2'd2, '0);
        tick();
        checks++; if (bus.itr !== 1'b0 || bus.in_service !== 1'b0 || bus.pending !== 4'b0001) begin failures++; $display("FAIL eoi_idle: itr %0b svc %0b pending %b want 0/0/0001", bus.itr, bus.in_service, bus.pending); end
    endtask

    task automatic test_reset_mid();
        cmd(2'd0, 4'b1111);
        bus.irq_in = 4'b0010; tick();
        bus.irq_in = 4'b1010; tick();
        checks++; if (bus.itr !== 1'b1) begin failures++; $display("FAIL midrst_pre: itr %0b want 1", bus.itr); end
        do_reset();
        checks++; if (bus.itr !== 1'b0 || bus.pending !== '0 || bus.mask !== '0 || bus.in_service !== 1'b0 || bus.src_id !== '0) begin
            failures++; $display("FAIL midrst: itr %0b pend %b mask %b svc %0b src %0d want all 0", bus.itr, bus.pending, bus.mask, bus.in_service, bus.src_id);
        end
        cmd(2'd0, 4'b1111);
        bus.irq_in = 4'b0100; tick();
        bus.irq_in = '0; tick();
        checks++; if (bus.itr !== 1'b1 || bus.src_id !== 2'd2) begin failures++; $display("FAIL midrst_idle: itr %0b src %0d want 1/2", bus.itr, bus.src_id); end
        ack_and_eoi();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 149) == 0);
            bus.irq_in     = bus.irq_in ^ (NSRC'($urandom) & NSRC'($urandom));
            bus.cfg_we     = ($urandom_range(0, 3) == 0);
            bus.cfg_sel    = 2'($urandom);
            bus.cfg_data   = NSRC'($urandom);
            bus.instr_addr = ($urandom_range(0, 3) == 0) ? MINSTW'(ITRADD) : MINSTW'($urandom);
            tick();
            checks++; if (bus.itr !== (m_phase == 1)) begin failures++; $display("FAIL rnd_itr @%0d: got %0b want %0b", n, bus.itr, (m_phase == 1)); end
            checks++; if (bus.in_service !== (m_phase == 2)) begin failures++; $display("FAIL rnd_svc @%0d: got %0b want %0b", n, bus.in_service, (m_phase == 2)); end
            checks++; if (bus.src_id !== IDW'(m_src)) begin failures++; $display("FAIL rnd_src @%0d: got %0d want %0d", n, bus.src_id, m_src); end
            checks++; if (bus.pending !== m_pend) begin failures++; $display("FAIL rnd_pend @%0d: got %b want %b", n, bus.pending, m_pend); end
            checks++; if (bus.mask !== m_mask) begin failures++; $display("FAIL rnd_mask @%0d: got %b want %b", n, bus.mask, m_mask); end
        end
        rst = 1'b0; bus.cfg_we = 1'b0; bus.irq_in = '0; bus.instr_addr = '0;
    endtask

    initial begin
        bus.irq_in = '0; bus.instr_addr = '0;
        bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_data = '0;
        test_reset();
        test_basic();
        test_masked();
        test_priority();
`ifdef ITR_CTRL_RR_EN
        test_round_robin();
`endif
        test_set_beats_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
